fitbit_step_tracker: RTL and testbench

// Receive end of the pedometer pulse interface: consumes the PULSES stream driven by the

---
 rtl/fitbit_pkg.sv | 28 ++
 rtl/pulse_sync_edge.sv | 38 +++
 rtl/fitbit_step_tracker.sv | 179 +++++++++++++++++
 tb/tb_fitbit_step_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fitbit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fitbit_pkg
// Description : Shared constants and types for the step tracker: the
//               high-activity FSM state type, saturation limits, and the
//               default thresholds and tick rate shared with the pulse
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fitbit_pkg;

    localparam int CLK_HZ_DEFAULT       = 100_000_000;
    localparam int STEPS_PER_HM_DEFAULT = 1024;
    localparam int OVER_THRESH_DEFAULT  = 32;
    localparam int HIGH_THRESH_DEFAULT  = 64;
    localparam int HIGH_MIN_RUN_DEFAULT = 60;

    localparam int STEP_MAX      = 9999;
    localparam int EARLY_WINDOW  = 9;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_CANDIDATE = 2'd1,
        HS_ACTIVE    = 2'd2
    } hs_state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_edge
// Description : Brings the asynchronous step pulse into the clock domain with
//               a two-flop synchroniser and flags each rising edge.
// Ports       : clk_i   - system clock
//               rst_ni  - asynchronous active-low reset
//               pulse_i - raw step pulse, asynchronous to clk_i
//               rise_o  - one-cycle strobe per synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/fitbit_step_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fitbit_step_tracker
// Description : Counts step pulses and derives total steps, distance,
//               early-activity seconds and sustained high-activity time.
// Ports       : CLK        - system clock
//               RESET_N    - asynchronous active-low reset
//               START      - 1 = tracking enabled, 0 = statistics frozen
//               PULSES     - step pulse, asynchronous to CLK
//               STEP_COUNT - total steps, saturating at 9999
//               DIST_HM    - distance in half-miles
//               EARLY_SECS - seconds among 1..9 above OVER_THRESH steps
//               HIGH_SECS  - credited high-activity seconds, saturating
//               SEC_TICK   - one-cycle strobe at each second boundary
// Revision    : 1.0 - initial release
// ============================================================================
module fitbit_step_tracker
    import fitbit_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int STEPS_PER_HM = STEPS_PER_HM_DEFAULT,
    parameter int OVER_THRESH  = OVER_THRESH_DEFAULT,
    parameter int HIGH_THRESH  = HIGH_THRESH_DEFAULT,
    parameter int HIGH_MIN_RUN = HIGH_MIN_RUN_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        PULSES,
    output logic [13:0] STEP_COUNT,
    output logic [3:0]  DIST_HM,
    output logic [3:0]  EARLY_SECS,
    output logic [15:0] HIGH_SECS,
    output logic        SEC_TICK
);

    localparam int              TW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TW-1:0]   TIMER_LAST   = TW'(CLK_HZ - 1);
    localparam int              HM_SHIFT     = $clog2(STEPS_PER_HM);
    localparam logic [13:0]     STEP_MAX_W   = 14'(STEP_MAX);
    localparam logic [7:0]      OVER_W       = 8'(OVER_THRESH);
    localparam logic [7:0]      HIGH_W       = 8'(HIGH_THRESH);
    localparam logic [6:0]      MIN_RUN_W    = 7'(HIGH_MIN_RUN);
    localparam logic [15:0]     MIN_CREDIT_W = 16'(HIGH_MIN_RUN);
    localparam logic [3:0]      EARLY_LAST_W = 4'(EARLY_WINDOW);

    logic            rise_w;
    logic            step_w;
    logic            tick_w;
    logic [7:0]      rate_w;
    logic [15:0]     credit_w;
    logic [16:0]     high_sum_w;

    logic [TW-1:0]   timer_q,      timer_d;
    logic [7:0]      sec_steps_q,  sec_steps_d;
    logic [3:0]      elapsed_q,    elapsed_d;
    logic [13:0]     step_count_q, step_count_d;
    logic [3:0]      early_q,      early_d;
    logic [15:0]     high_q,       high_d;
    logic [6:0]      run_q,        run_d;
    hs_state_e       state_q,      state_d;

    pulse_sync_edge u_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .pulse_i (PULSES),
        .rise_o  (rise_w)
    );

    assign step_w = rise_w & START;
    assign tick_w = START & (timer_q == TIMER_LAST);

    // A step landing on the tick cycle still belongs to the closing second.
    assign rate_w = (step_w && (sec_steps_q != 8'hFF)) ? sec_steps_q + 8'd1 : sec_steps_q;

    always_comb begin
        timer_d      = timer_q;
        sec_steps_d  = sec_steps_q;
        elapsed_d    = elapsed_q;
        step_count_d = step_count_q;
        early_d      = early_q;
        run_d        = run_q;
        state_d      = state_q;
        credit_w     = 16'd0;

        if (!START) begin
            timer_d     = '0;
            sec_steps_d = 8'd0;
            run_d       = 7'd0;
            state_d     = HS_IDLE;
        end else begin
            if (step_w && (step_count_q != STEP_MAX_W)) begin
                step_count_d = step_count_q + 14'd1;
            end

            if (tick_w) begin
                timer_d     = '0;
                sec_steps_d = 8'd0;
                if (elapsed_q != 4'hF) begin
                    elapsed_d = elapsed_q + 4'd1;
                end
                // elapsed_q < 9 means the second just closed is one of 1..9.
                if ((elapsed_q < EARLY_LAST_W) && (rate_w > OVER_W)) begin
                    early_d = early_q + 4'd1;
                end

                case (state_q)
                    HS_IDLE: begin
                        if (rate_w >= HIGH_W) begin
                            state_d = HS_CANDIDATE;
                            run_d   = 7'd1;
                        end
                    end
                    HS_CANDIDATE: begin
                        if (rate_w >= HIGH_W) begin
                            run_d = run_q + 7'd1;
                            // The whole qualifying run is credited at once.
                            if ((run_q + 7'd1) == MIN_RUN_W) begin
                                state_d  = HS_ACTIVE;
                                credit_w = MIN_CREDIT_W;
                            end
                        end else begin
                            state_d = HS_IDLE;
                            run_d   = 7'd0;
                        end
                    end
                    HS_ACTIVE: begin
                        if (rate_w >= HIGH_W) begin
                            credit_w = 16'd1;
                        end else begin
                            state_d = HS_IDLE;
                            run_d   = 7'd0;
                        end
                    end
                    default: begin
                        state_d = HS_IDLE;
                        run_d   = 7'd0;
                    end
                endcase
            end else begin
                timer_d     = timer_q + TW'(1);
                sec_steps_d = rate_w;
            end
        end

        high_sum_w = {1'b0, high_q} + {1'b0, credit_w};
        high_d     = high_sum_w[16] ? 16'hFFFF : high_sum_w[15:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            timer_q      <= '0;
            sec_steps_q  <= 8'd0;
            elapsed_q    <= 4'd0;
            step_count_q <= 14'd0;
            early_q      <= 4'd0;
            high_q       <= 16'd0;
            run_q        <= 7'd0;
            state_q      <= HS_IDLE;
        end else begin
            timer_q      <= timer_d;
            sec_steps_q  <= sec_steps_d;
            elapsed_q    <= elapsed_d;
            step_count_q <= step_count_d;
            early_q      <= early_d;
            high_q       <= high_d;
            run_q        <= run_d;
            state_q      <= state_d;
        end
    end

    assign STEP_COUNT = step_count_q;
    assign DIST_HM    = 4'(step_count_q >> HM_SHIFT);
    assign EARLY_SECS = early_q;
    assign HIGH_SECS  = high_q;
    assign SEC_TICK   = tick_w;

endmodule
`default_nettype wire

// File: tb/tb_fitbit_step_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fitbit_step_tracker
// Description : Self-checking bench for fitbit_step_tracker. Step pulses are
//               planned per second, and the expected statistics are computed
//               from the per-second step rates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fitbit_step_tracker;

    localparam int HZ      = 1000;
    localparam int MIN_RUN = 8;
    localparam int MAXE    = 24000;
    localparam int MAXS    = 32;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        PULSES = 1'b0;
    logic [13:0] STEP_COUNT;
    logic [3:0]  DIST_HM;
    logic [3:0]  EARLY_SECS;
    logic [15:0] HIGH_SECS;
    logic        SEC_TICK;

    fitbit_step_tracker #(
        .CLK_HZ       (HZ),
        .STEPS_PER_HM (1024),
        .OVER_THRESH  (32),
        .HIGH_THRESH  (64),
        .HIGH_MIN_RUN (MIN_RUN)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .PULSES     (PULSES),
        .STEP_COUNT (STEP_COUNT),
        .DIST_HM    (DIST_HM),
        .EARLY_SECS (EARLY_SECS),
        .HIGH_SECS  (HIGH_SECS),
        .SEC_TICK   (SEC_TICK)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // step_at[n] = 1 means a step must be counted at the n-th START-high edge.
    bit step_at [0:MAXE];
    int rates   [0:MAXS-1];

    task automatic check_value(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i <= MAXE; i++) step_at[i] = 1'b0;
        for (int i = 0; i < MAXS; i++) rates[i] = 0;
    endtask

    // k steps in second s (1-based) at random spaced positions; with
    // coincident set, the last step lands on the second's final edge.
    task automatic plan_second(input int s, input int k, input bit coincident);
        int base, kn, off;
        base = (s - 1) * HZ;
        rates[s-1] = k;
        if (k == 0) return;
        kn  = coincident ? k - 1 : k;
        off = $urandom_range(3, HZ - 4 - 2 * kn);
        for (int i = 0; i < kn; i++) step_at[base + off + 2 * i] = 1'b1;
        if (coincident) step_at[base + HZ] = 1'b1;
    endtask

    // A step counted at edge n needs PULSES sampled high at edge n-2.
    task automatic run_seconds(input int s0, input int s1);
        for (int m = (s0 - 1) * HZ + 1; m <= s1 * HZ; m++) begin
            START  = 1'b1;
            PULSES = step_at[m + 2];
            #1;
            if (m % HZ == 0)      check_value("sec_tick_high", SEC_TICK, 1);
            else if (m % HZ == 1) check_value("sec_tick_low", SEC_TICK, 0);
            @(posedge CLK);
            @(negedge CLK);
        end
        PULSES = 1'b0;
    endtask

    task automatic expect_stats(input string tag, input int nsec);
        int tot, sc, early, high, streak, r;
        tot = 0; early = 0; high = 0; streak = 0;
        for (int i = 0; i < nsec; i++) begin
            tot += rates[i];
            r = (rates[i] > 255) ? 255 : rates[i];
            if (i < 9 && r > 32) early++;
            if (r >= 64) begin
                streak++;
                if (streak == MIN_RUN)     high += MIN_RUN;
                else if (streak > MIN_RUN) high += 1;
            end else begin
                streak = 0;
            end
        end
        sc   = (tot > 9999) ? 9999 : tot;
        high = (high > 65535) ? 65535 : high;
        check_value({tag, "_steps"}, STEP_COUNT, sc);
        check_value({tag, "_dist"},  DIST_HM,    sc / 1024);
        check_value({tag, "_early"}, EARLY_SECS, early);
        check_value({tag, "_high"},  HIGH_SECS,  high);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_steps"}, STEP_COUNT, 0);
        check_value({tag, "_dist"},  DIST_HM,    0);
        check_value({tag, "_early"}, EARLY_SECS, 0);
        check_value({tag, "_high"},  HIGH_SECS,  0);
        check_value({tag, "_tick"},  SEC_TICK,   0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        START   = 1'b0;
        PULSES  = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check_all_zero("reset");

        // Random per-second rates, then an asynchronous reset mid-second
        clear_plan();
        for (int s = 1; s <= 5; s++) begin
            int k;
            k = $urandom_range(0, 140);
            plan_second(s, k, (k > 0) && ($urandom_range(0, 1) == 1));
        end
        for (int s = 1; s <= 5; s++) begin
            run_seconds(s, s);
            expect_stats("random", s);
        end
        repeat (300) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge CLK);
        START   = 1'b0;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Counting restarts from 0; 100 steps then 1024 steps in total
        clear_plan();
        plan_second(1, 100, 1'b0);
        plan_second(2, 462, 1'b0);
        plan_second(3, 462, 1'b1);
        run_seconds(1, 1);
        expect_stats("count100", 1);
        run_seconds(2, 3);
        expect_stats("count1024", 3);

        // 40 steps/s for 12 s: only seconds 1..9 count as early
        do_reset();
        clear_plan();
        for (int s = 1; s <= 12; s++) plan_second(s, 40, 1'b0);
        run_seconds(1, 12);
        expect_stats("early40", 12);

        // 20 steps/s for 9 s: never above the early threshold
        do_reset();
        clear_plan();
        for (int s = 1; s <= 9; s++) plan_second(s, 20, 1'b0);
        run_seconds(1, 9);
        expect_stats("early20", 9);

        // Runs at exactly 64 steps/s, each with one step on the tick cycle:
        // one run short of the minimum, a slow second, then a credited run.
        do_reset();
        clear_plan();
        for (int s = 1; s <= MIN_RUN - 1; s++) plan_second(s, 64, 1'b1);
        plan_second(MIN_RUN, 10, 1'b0);
        for (int s = MIN_RUN + 1; s <= 2 * MIN_RUN + 5; s++) plan_second(s, 64, 1'b1);
        run_seconds(1, MIN_RUN);
        expect_stats("short_run", MIN_RUN);
        run_seconds(MIN_RUN + 1, 2 * MIN_RUN - 1);
        expect_stats("run_minus1", 2 * MIN_RUN - 1);
        run_seconds(2 * MIN_RUN, 2 * MIN_RUN);
        expect_stats("run_exact", 2 * MIN_RUN);
        run_seconds(2 * MIN_RUN + 1, 2 * MIN_RUN + 5);
        expect_stats("run_plus5", 2 * MIN_RUN + 5);

        // START=0 for 5 s with PULSES toggling: statistics frozen
        START = 1'b0;
        for (int i = 0; i < 5 * HZ; i++) begin
            PULSES = ~PULSES;
            #1;
            if (i % HZ == HZ - 1) check_value("frozen_tick", SEC_TICK, 0);
            @(posedge CLK);
            @(negedge CLK);
        end
        PULSES = 1'b0;
        repeat (3) @(negedge CLK);
        expect_stats("frozen", 2 * MIN_RUN + 5);

        // 10560 steps: count saturates at 9999
        do_reset();
        clear_plan();
        for (int s = 1; s <= 22; s++) plan_second(s, 480, s[0]);
        run_seconds(1, 22);
        expect_stats("saturate", 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
